// File: rtl/cic_pkg.sv
// Shared helpers for the multi-channel CIC decimator: width arithmetic and
// the rounding offset used when the output drops low-order bits.
package cic_pkg;

  // Ceiling log2 for elaboration-time width calculations (clog2(1) == 0).
  function automatic int clog2(input longint unsigned value);
    int result;
    result = 0;
    while ((64'd1 << result) < value) result++;
    return result;
  endfunction

  // Worst-case register growth through N integrator/comb pairs.
  function automatic int bitgrowth(input int n, input int m, input int maxrate);
    return n * clog2(64'(m * maxrate));
  endfunction

  // Half an output LSB when drop_bits are truncated; zero when nothing is dropped.
  function automatic longint unsigned round_offset(input int drop_bits);
    return (drop_bits > 0) ? (64'd1 << (drop_bits - 1)) : 64'd0;
  endfunction

  // Rounding offset for the default 16-in / 16-out, N=3, M=1, MAXRATE=64 build.
  localparam int              DEF_DROP_BITS    = 16 + bitgrowth(3, 1, 64) - 16;
  localparam longint unsigned DEF_ROUND_OFFSET = round_offset(DEF_DROP_BITS);

endpackage

// File: rtl/cic_decim_lane.sv
// One CIC channel: pipelined integrators at the input rate, a sampler loaded
// on the decimation strobe, a valid-driven comb pipeline and round/saturate.
module cic_decim_lane
  import cic_pkg::*;
#(
  parameter int DIN_W  = 16,
  parameter int DOUT_W = 16,
  parameter int M      = 1,
  parameter int N      = 3,
  parameter int BG     = 18
) (
  input  logic              clk_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              strobe_i,
  input  logic [N:0]        vld_i,
  input  logic [DIN_W-1:0]  data_i,
  output logic [DOUT_W-1:0] data_o
);

  localparam int           W   = DIN_W + BG;
  localparam int           D   = W - DOUT_W;
  localparam logic [W-1:0] RND = W'(round_offset(D));

  // Arithmetic is modular in W bits; the sign is read from the MSB only where needed.
  logic [W-1:0]      int_q   [N];
  logic [W-1:0]      samp_q;
  logic [W-1:0]      comb_q  [N];
  logic [W-1:0]      dly_q   [N][M];
  logic [W-1:0]      comb_in [N];
  logic [W-1:0]      rnd_sum;
  logic [DOUT_W-1:0] out_d;
  logic [DOUT_W-1:0] out_q;
  logic              unused_rnd_bits;

  // Integrator chain; each stage adds the previous stage's registered value.
  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      for (int k = 0; k < N; k++) int_q[k] <= '0;
    end else if (valid_i) begin
      int_q[0] <= int_q[0] + {{BG{data_i[DIN_W-1]}}, data_i};
      for (int k = 1; k < N; k++) int_q[k] <= int_q[k] + int_q[k-1];
    end
  end

  // Sampler captures the last integrator on each decimation strobe.
  always_ff @(posedge clk_i) begin
    if (flush_i)       samp_q <= '0;
    else if (strobe_i) samp_q <= int_q[N-1];
  end

  // Comb stage inputs: sampler feeds stage 0, each stage feeds the next.
  always_comb begin
    comb_in[0] = samp_q;
    for (int k = 1; k < N; k++) comb_in[k] = comb_q[k-1];
  end

  // Comb pipeline; each stage and its delay line move only on that stage's valid.
  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      for (int k = 0; k < N; k++) begin
        comb_q[k] <= '0;
        for (int j = 0; j < M; j++) dly_q[k][j] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (vld_i[k]) begin
          comb_q[k]   <= comb_in[k] - dly_q[k][M-1];
          dly_q[k][0] <= comb_in[k];
          for (int j = 1; j < M; j++) dly_q[k][j] <= dly_q[k][j-1];
        end
      end
    end
  end

  // Round half up, then clamp to max positive if the add carried into the sign bit.
  always_comb begin
    rnd_sum = comb_q[N-1] + RND;
    if (!comb_q[N-1][W-1] && rnd_sum[W-1]) out_d = {1'b0, {(DOUT_W-1){1'b1}}};
    else                                   out_d = rnd_sum[W-1 -: DOUT_W];
  end

  // The dropped fraction bits only matter through the carry they produce.
  assign unused_rnd_bits = ^rnd_sum;

  // Output register holds until the next decimated sample arrives.
  always_ff @(posedge clk_i) begin
    if (flush_i)        out_q <= '0;
    else if (vld_i[N])  out_q <= out_d;
  end

  assign data_o = out_q;

endmodule

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator top: ratio latch, shared rate counter, valid
// shift register and one cic_decim_lane per channel.
module cic_decim_mc
  import cic_pkg::*;
#(
  parameter int DATAIN_WIDTH  = 16,
  parameter int DATAOUT_WIDTH = 16,
  parameter int NUM_CHANNELS  = 2,
  parameter int M             = 1,
  parameter int N             = 3,
  parameter int MAXRATE       = 64
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   clear_i,
  input  logic [clog2(MAXRATE+1)-1:0]            ratio_i,
  input  logic                                   valid_i,
  input  logic [NUM_CHANNELS*DATAIN_WIDTH-1:0]   data_i,
  output logic [NUM_CHANNELS*DATAOUT_WIDTH-1:0]  data_o,
  output logic                                   valid_o
);

  localparam int            BITGROWTH = bitgrowth(N, M, MAXRATE);
  localparam int            RW        = clog2(MAXRATE + 1);
  localparam logic [RW-1:0] RMAX      = RW'(MAXRATE);

  logic          flush;
  logic          strobe;
  logic [RW-1:0] ratio_eff;
  logic [RW-1:0] ratio_q;
  logic [RW-1:0] cnt_q;
  logic [N+1:0]  vld_q;

  assign flush = rst_i | clear_i;

  // Clamp the requested ratio into 1..MAXRATE.
  always_comb begin
    ratio_eff = ratio_i;
    if (ratio_i == '0)       ratio_eff = RW'(1);
    else if (ratio_i > RMAX) ratio_eff = RMAX;
  end

  assign strobe = valid_i & ~flush & (cnt_q == ratio_q - RW'(1));

  // Rate counter; a new ratio is only picked up at flush or at a frame boundary.
  always_ff @(posedge clk_i) begin
    if (flush || strobe) begin
      cnt_q   <= '0;
      ratio_q <= ratio_eff;
    end else if (valid_i) begin
      cnt_q <= cnt_q + RW'(1);
    end
  end

  // Valid shift register: bit 0 = sampler, bits 1..N = combs, bit N+1 = output.
  always_ff @(posedge clk_i) begin
    if (flush) vld_q <= '0;
    else       vld_q <= {vld_q[N:0], strobe};
  end

  assign valid_o = vld_q[N+1];

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
    cic_decim_lane #(
      .DIN_W  (DATAIN_WIDTH),
      .DOUT_W (DATAOUT_WIDTH),
      .M      (M),
      .N      (N),
      .BG     (BITGROWTH)
    ) u_lane (
      .clk_i    (clk_i),
      .flush_i  (flush),
      .valid_i  (valid_i),
      .strobe_i (strobe),
      .vld_i    (vld_q[N:0]),
      .data_i   (data_i[c*DATAIN_WIDTH +: DATAIN_WIDTH]),
      .data_o   (data_o[c*DATAOUT_WIDTH +: DATAOUT_WIDTH])
    );
  end

endmodule

// File: tb/tb_cic_decim_mc.sv
// Scoreboard bench for cic_decim_mc at default parameters: a sample-level
// model predicts every decimated output and its arrival cycle.
module tb_cic_decim_mc;

  localparam int NCH  = 2;
  localparam int DIN  = 16;
  localparam int DOUT = 16;
  localparam int NS   = 3;
  localparam int W    = 34;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                clear_i;
  logic [6:0]          ratio_i;
  logic                valid_i;
  logic [NCH*DIN-1:0]  data_i;
  logic [NCH*DOUT-1:0] data_o;
  logic                valid_o;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     pulses   = 0;
  longint cyc      = 0;
  bit     armed    = 1'b0;

  typedef struct packed {
    longint                      due;
    logic [NCH-1:0][DOUT-1:0]    d;
  } exp_t;

  exp_t           sb[$];
  logic [DOUT-1:0] last_out [NCH];
  logic [W-1:0]    m_int [NCH][NS];
  logic [W-1:0]    m_dly [NCH][NS];
  int              m_cnt;
  int              m_ratio;

  cic_decim_mc dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .ratio_i (ratio_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clamp_ratio(input logic [6:0] r);
    if (r == 7'd0) return 1;
    if (r > 7'd64) return 64;
    return int'(r);
  endfunction

  function automatic logic [DOUT-1:0] rnd_sat(input logic [W-1:0] w);
    logic [W-1:0] t;
    t = w + 34'd131072;
    if (!w[W-1] && t[W-1]) return 16'h7fff;
    return t[W-1:18];
  endfunction

  // Monitor then model, once per cycle away from the active edge.
  always @(negedge clk_i) begin : mon
    exp_t         e;
    logic [W-1:0] x, c, t, old2;
    if (armed) begin
      if (valid_o) begin
        pulses++;
        if (sb.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc, e.due);
          for (int ch = 0; ch < NCH; ch++)
            chk($sformatf("data_ch%0d", ch), longint'($signed(data_o[ch*DOUT +: DOUT])),
                longint'($signed(e.d[ch])));
        end
        for (int ch = 0; ch < NCH; ch++) last_out[ch] = data_o[ch*DOUT +: DOUT];
      end else begin
        for (int ch = 0; ch < NCH; ch++)
          chk("hold", longint'(data_o[ch*DOUT +: DOUT]), longint'(last_out[ch]));
      end
    end
    if (rst_i || clear_i) begin
      sb.delete();
      for (int ch = 0; ch < NCH; ch++) begin
        last_out[ch] = '0;
        for (int k = 0; k < NS; k++) begin
          m_int[ch][k] = '0;
          m_dly[ch][k] = '0;
        end
      end
      m_cnt   = 0;
      m_ratio = clamp_ratio(ratio_i);
      armed   = 1'b1;
    end else if (valid_i && armed) begin
      e     = '0;
      e.due = cyc + NS + 2;
      for (int ch = 0; ch < NCH; ch++) begin
        x    = W'($signed(data_i[ch*DIN +: DIN]));
        old2 = m_int[ch][2];
        m_int[ch][2] = m_int[ch][2] + m_int[ch][1];
        m_int[ch][1] = m_int[ch][1] + m_int[ch][0];
        m_int[ch][0] = m_int[ch][0] + x;
        c = old2;
        for (int k = 0; k < NS; k++) begin
          t = c - m_dly[ch][k];
          if (m_cnt == m_ratio - 1) m_dly[ch][k] = c;
          c = t;
        end
        e.d[ch] = rnd_sat(c);
      end
      if (m_cnt == m_ratio - 1) begin
        sb.push_back(e);
        m_cnt   = 0;
        m_ratio = clamp_ratio(ratio_i);
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input bit use_clear, input int r);
    ratio_i = 7'(r);
    if (use_clear) clear_i = 1'b1;
    else           rst_i   = 1'b1;
    tick();
    rst_i   = 1'b0;
    clear_i = 1'b0;
    pulses  = 0;
  endtask

  task automatic feed(input int n, input int x0, input int x1, input bit rnd, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
        valid_i = 1'b0;
        repeat ($urandom_range(3, 1)) tick();
      end
      valid_i = 1'b1;
      if (rnd) data_i = {16'($urandom), 16'($urandom)};
      else     data_i = {16'(x1), 16'(x0)};
      tick();
    end
    valid_i = 1'b0;
  endtask

  task automatic drain();
    repeat (NS + 4) tick();
  endtask

  task automatic dc_test(input string tag, input int r, input int x0, input int x1,
                         input int frames, input int e0, input int e1);
    do_reset(1'b0, r);
    feed(frames * clamp_ratio(7'(r)), x0, x1, 1'b0, 0);
    drain();
    chk({tag, "_ch0"}, longint'($signed(last_out[0])), e0);
    chk({tag, "_ch1"}, longint'($signed(last_out[1])), e1);
    chk({tag, "_pulses"}, pulses, frames);
  endtask

  task automatic mid_reset(input bit use_clear);
    do_reset(use_clear, 4);
    feed(4, 0, 0, 1'b1, 0);
    valid_i = 1'b1;
    data_i  = {16'($urandom), 16'($urandom)};
    if (use_clear) clear_i = 1'b1;
    else           rst_i   = 1'b1;
    tick();
    rst_i   = 1'b0;
    clear_i = 1'b0;
    valid_i = 1'b0;
    pulses  = 0;
    repeat (NS + 4) begin
      chk("flush_valid", valid_o, 0);
      chk("flush_data", longint'(data_o), 0);
      tick();
    end
    feed(40, 0, 0, 1'b1, 0);
    drain();
    chk("post_flush_pulses", pulses, 10);
  endtask

  initial begin
    rst_i   = 1'b1;
    clear_i = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    ratio_i = 7'd64;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_data", longint'(data_o), 0);

    dc_test("dc_r64",   64,   1000,   1000, 6,  1000,   1000);
    dc_test("dc_r32",   32,   1000,   1000, 6,   125,    125);
    dc_test("rnd_pos",  32,      3,      4, 6,     0,      1);
    dc_test("rnd_neg",  32,     -4,     -5, 6,     0,     -1);
    dc_test("fullscale",64,  32767, -32768, 6, 32767, -32768);
    dc_test("clamp_hi",100,   1000,   1000, 6,  1000,   1000);

    do_reset(1'b0, 5);
    feed(50, 0, 0, 1'b1, 50);
    drain();
    chk("gaps_r5_pulses", pulses, 10);

    do_reset(1'b0, 0);
    feed(10, 0, 0, 1'b1, 0);
    drain();
    chk("clamp_zero_pulses", pulses, 10);

    do_reset(1'b0, 8);
    feed(4, 0, 0, 1'b1, 0);
    ratio_i = 7'd16;
    feed(36, 0, 0, 1'b1, 0);
    drain();
    chk("ratio_change_pulses", pulses, 3);

    mid_reset(1'b0);
    mid_reset(1'b1);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
